// File: rtl/hash_table_set_assoc_if.sv
// hash_table_set_assoc_if: request/response channel of the set-associative hash table.
interface hash_table_set_assoc_if #(
  parameter int KEY_W = 32,
  parameter int VAL_W = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [KEY_W-1:0] req_key;
  logic [VAL_W-1:0] req_value;
  logic             resp_valid;
  logic             resp_ready;
  logic             resp_hit;
  logic             resp_ok;
  logic [VAL_W-1:0] resp_value;
  modport slave (
    input  req_valid, req_op, req_key, req_value, resp_ready,
    output req_ready, resp_valid, resp_hit, resp_ok, resp_value
  );
  modport master (
    output req_valid, req_op, req_key, req_value, resp_ready,
    input  req_ready, resp_valid, resp_hit, resp_ok, resp_value
  );
endinterface

// File: rtl/hash_table_set_assoc.sv
// hash_table_set_assoc: WAYS-way bucketed key/value table with a fully associative overflow stash.
// Optional HT_STATS_EN adds occupancy and failed-insert counters.
module hash_table_set_assoc #(
  parameter int KEY_W   = 32,
  parameter int VAL_W   = 32,
  parameter int BUCKETS = 256,
  parameter int WAYS    = 4,
  parameter int STASH   = 4
) (
  input logic clk,
  input logic reset,
  hash_table_set_assoc_if.slave bus
`ifdef HT_STATS_EN
  ,
  output logic [$clog2(BUCKETS*WAYS+STASH+1)-1:0] occupancy,
  output logic [15:0]                             fail_cnt
`endif
);
  localparam int IDX_W = $clog2(BUCKETS);
  localparam int WW    = WAYS > 1 ? $clog2(WAYS) : 1;
  localparam int SW    = STASH > 1 ? $clog2(STASH) : 1;
  typedef enum logic [2:0] {IDLE, PROBE, UPDATE, CLEAR, RESP} state_t;
  state_t           state_q;
  logic             ready_q, resp_valid_q, resp_hit_q, resp_ok_q;
  logic [VAL_W-1:0] resp_value_q;
  logic [1:0]       op_q;
  logic [KEY_W-1:0] key_q;
  logic [VAL_W-1:0] val_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W:0]   clr_q;
  logic [WAYS-1:0]  vld_q [BUCKETS];
  logic [KEY_W-1:0] bkey_q [BUCKETS][WAYS];
  logic [VAL_W-1:0] bval_q [BUCKETS][WAYS];
  logic [STASH-1:0] svld_q;
  logic [KEY_W-1:0] skey_q [STASH];
  logic [VAL_W-1:0] sval_q [STASH];
  logic             wm_d, wf_d, sm_d, sf_d, wm_q, wf_q, sm_q, sf_q;
  logic [WW-1:0]    wm_i_d, wf_i_d, wm_i_q, wf_i_q, wr_way_i;
  logic [SW-1:0]    sm_i_d, sf_i_d, sm_i_q, sf_i_q, wr_st_i;
  logic             upd_ins, upd_del, wr_way, wr_st, new_slot, ins_fail, del_hit;
  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_hit   = resp_hit_q;
  assign bus.resp_ok    = resp_ok_q;
  assign bus.resp_value = resp_value_q;
  function automatic logic [IDX_W-1:0] fold(input logic [KEY_W-1:0] k);
    logic [IDX_W-1:0] h;
    h = '0;
    for (int b = 0; b < KEY_W; b++) h[b % IDX_W] ^= k[b];
    return h;
  endfunction
  // Descending scans so the lowest matching/free index is the one left standing.
  always_comb begin
    wm_d = 1'b0; wm_i_d = '0; wf_d = 1'b0; wf_i_d = '0;
    sm_d = 1'b0; sm_i_d = '0; sf_d = 1'b0; sf_i_d = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (vld_q[idx_q][w] && bkey_q[idx_q][w] == key_q) begin wm_d = 1'b1; wm_i_d = WW'(w); end
      if (!vld_q[idx_q][w]) begin wf_d = 1'b1; wf_i_d = WW'(w); end
    end
    for (int s = STASH - 1; s >= 0; s--) begin
      if (svld_q[s] && skey_q[s] == key_q) begin sm_d = 1'b1; sm_i_d = SW'(s); end
      if (!svld_q[s]) begin sf_d = 1'b1; sf_i_d = SW'(s); end
    end
  end
  always_comb begin
    upd_ins  = state_q == UPDATE && op_q == 2'd1;
    upd_del  = state_q == UPDATE && op_q == 2'd2;
    wr_way   = upd_ins && (wm_q || (!sm_q && wf_q));
    wr_way_i = wm_q ? wm_i_q : wf_i_q;
    wr_st    = upd_ins && !wm_q && (sm_q || (!wf_q && sf_q));
    wr_st_i  = sm_q ? sm_i_q : sf_i_q;
    new_slot = upd_ins && !wm_q && !sm_q && (wf_q || sf_q);
    ins_fail = upd_ins && !(wm_q || sm_q || wf_q || sf_q);
    del_hit  = upd_del && (wm_q || sm_q);
  end
  always_ff @(posedge clk) begin
    if (wr_way) begin
      bkey_q[idx_q][wr_way_i] <= key_q;
      bval_q[idx_q][wr_way_i] <= val_q;
    end
    if (wr_st) begin
      skey_q[wr_st_i] <= key_q;
      sval_q[wr_st_i] <= val_q;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_ok_q    <= 1'b0;
      resp_value_q <= '0;
      clr_q        <= '0;
      svld_q       <= '0;
      for (int b = 0; b < BUCKETS; b++) vld_q[b] <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.req_valid && ready_q) begin
          op_q    <= bus.req_op;
          key_q   <= bus.req_key;
          val_q   <= bus.req_value;
          idx_q   <= fold(bus.req_key);
          clr_q   <= '0;
          ready_q <= 1'b0;
          state_q <= bus.req_op == 2'd3 ? CLEAR : PROBE;
        end
        PROBE: begin
          wm_q <= wm_d; wm_i_q <= wm_i_d; wf_q <= wf_d; wf_i_q <= wf_i_d;
          sm_q <= sm_d; sm_i_q <= sm_i_d; sf_q <= sf_d; sf_i_q <= sf_i_d;
          state_q <= UPDATE;
        end
        UPDATE: begin
          if (wr_way) vld_q[idx_q][wr_way_i] <= 1'b1;
          if (wr_st) svld_q[wr_st_i] <= 1'b1;
          if (upd_del && wm_q) vld_q[idx_q][wm_i_q] <= 1'b0;
          else if (upd_del && sm_q) svld_q[sm_i_q] <= 1'b0;
          resp_hit_q   <= wm_q || sm_q;
          resp_ok_q    <= op_q == 2'd1 ? (wm_q || sm_q || wf_q || sf_q) : (wm_q || sm_q);
          resp_value_q <= op_q != 2'd0 ? '0 : wm_q ? bval_q[idx_q][wm_i_q] : sm_q ? sval_q[sm_i_q] : '0;
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end
        CLEAR: if (clr_q == (IDX_W+1)'(BUCKETS)) begin
          resp_hit_q   <= 1'b0;
          resp_ok_q    <= 1'b1;
          resp_value_q <= '0;
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end else begin
          vld_q[clr_q[IDX_W-1:0]] <= '0;
          if (clr_q == '0) svld_q <= '0;
          clr_q <= clr_q + 1'b1;
        end
        RESP: if (bus.resp_ready) begin
          resp_valid_q <= 1'b0;
          ready_q      <= 1'b1;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`ifdef HT_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      occupancy <= '0;
      fail_cnt  <= '0;
    end else begin
      if (state_q == CLEAR) occupancy <= '0;
      else if (new_slot) occupancy <= occupancy + 1'b1;
      else if (del_hit) occupancy <= occupancy - 1'b1;
      if (ins_fail && fail_cnt != 16'hFFFF) fail_cnt <= fail_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_hash_table_set_assoc.sv
// tb_hash_table_set_assoc: directed checks on a 4-bucket, 2-way, 2-entry-stash table.
module tb_hash_table_set_assoc;
  localparam int B = 4;
  logic        clk = 1'b0;
  logic        reset;
  logic        rh, rok;
  logic [31:0] rv;
  int          lat;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] keys [4] = '{32'h0, 32'h5, 32'hA, 32'hF};
  always #5 clk = ~clk;
  hash_table_set_assoc_if #(.KEY_W(32), .VAL_W(32)) bus ();
`ifdef HT_STATS_EN
  logic [3:0]  occupancy;
  logic [15:0] fail_cnt;
`endif
  hash_table_set_assoc #(.KEY_W(32), .VAL_W(32), .BUCKETS(B), .WAYS(2), .STASH(2)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
`ifdef HT_STATS_EN
    ,
    .occupancy(occupancy),
    .fail_cnt(fail_cnt)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic xact(input logic [1:0] op, input logic [31:0] k, input logic [31:0] v);
    bus.req_op = op; bus.req_key = k; bus.req_value = v;
    bus.req_valid = 1'b1; bus.resp_ready = 1'b1;
    @(posedge clk); #1 bus.req_valid = 1'b0;
    lat = 0;
    while (!bus.resp_valid && lat < 50) begin @(posedge clk); #1 lat++; end
    rh = bus.resp_hit; rok = bus.resp_ok; rv = bus.resp_value;
    @(posedge clk); #1;
  endtask
  initial begin
    int t;
    bus.req_valid = 1'b0; bus.resp_ready = 1'b0;
    bus.req_op = 2'd0; bus.req_key = '0; bus.req_value = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_req_ready", 32'(bus.req_ready), 1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 0);
    chk("rst_resp_hit", 32'(bus.resp_hit), 0);
    chk("rst_resp_ok", 32'(bus.resp_ok), 0);
    chk("rst_resp_value", bus.resp_value, 0);
`ifdef HT_STATS_EN
    chk("rst_occupancy", 32'(occupancy), 0);
    chk("rst_fail_cnt", 32'(fail_cnt), 0);
`endif
    xact(2'd1, 32'h1234, 32'hAA);
    chk("ins_hit", 32'(rh), 0); chk("ins_ok", 32'(rok), 1); chk("ins_lat", lat, 2);
    xact(2'd0, 32'h1234, 32'h0);
    chk("lk_hit", 32'(rh), 1); chk("lk_ok", 32'(rok), 1); chk("lk_val", rv, 32'hAA); chk("lk_lat", lat, 2);
    xact(2'd1, 32'h1234, 32'hBB);
    chk("upd_hit", 32'(rh), 1); chk("upd_ok", 32'(rok), 1);
    xact(2'd0, 32'h1234, 32'h0);
    chk("upd_lk_val", rv, 32'hBB);
    // 0x0, 0x5, 0xA, 0xF and 0x11 all fold to bucket 0
    for (int i = 0; i < 4; i++) begin
      xact(2'd1, keys[i], 32'h100 + keys[i]);
      chk("col_ins_hit", 32'(rh), 0); chk("col_ins_ok", 32'(rok), 1);
    end
    xact(2'd1, 32'h11, 32'h311);
    chk("full_ins_hit", 32'(rh), 0); chk("full_ins_ok", 32'(rok), 0);
    for (int i = 0; i < 4; i++) begin
      xact(2'd0, keys[i], 32'h0);
      chk("col_lk_hit", 32'(rh), 1); chk("col_lk_val", rv, 32'h100 + keys[i]);
    end
    xact(2'd0, 32'h11, 32'h0);
    chk("full_lk_hit", 32'(rh), 0); chk("full_lk_ok", 32'(rok), 0); chk("full_lk_val", rv, 0);
    xact(2'd1, 32'hF, 32'h2F);
    chk("st_upd_hit", 32'(rh), 1); chk("st_upd_ok", 32'(rok), 1);
    xact(2'd0, 32'hF, 32'h0);
    chk("st_upd_val", rv, 32'h2F);
    xact(2'd2, 32'h1234, 32'h0);
    chk("del1_hit", 32'(rh), 1); chk("del1_ok", 32'(rok), 1);
    xact(2'd2, 32'h1234, 32'h0);
    chk("del2_hit", 32'(rh), 0); chk("del2_ok", 32'(rok), 0);
    xact(2'd0, 32'h1234, 32'h0);
    chk("del_lk_hit", 32'(rh), 0); chk("del_lk_val", rv, 0);
    // Backpressure: a pending insert of 0x1234 must not be taken while the response waits
    bus.req_op = 2'd0; bus.req_key = 32'h5; bus.req_value = '0;
    bus.req_valid = 1'b1; bus.resp_ready = 1'b0;
    @(posedge clk); #1 bus.req_op = 2'd1; bus.req_key = 32'h1234; bus.req_value = 32'h77;
    t = 0;
    while (!bus.resp_valid && t < 50) begin @(posedge clk); #1 t++; end
    chk("bp_lat", t, 2);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", 32'(bus.resp_valid), 1);
      chk("bp_hit", 32'(bus.resp_hit), 1);
      chk("bp_val", bus.resp_value, 32'h105);
      chk("bp_req_ready", 32'(bus.req_ready), 0);
    end
    bus.req_valid = 1'b0; bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_done_valid", 32'(bus.resp_valid), 0);
    chk("bp_done_ready", 32'(bus.req_ready), 1);
    repeat (3) @(posedge clk);
    #1 chk("bp_idle_valid", 32'(bus.resp_valid), 0);
    xact(2'd0, 32'h1234, 32'h0);
    chk("bp_no_accept", 32'(rh), 0);
    xact(2'd2, 32'h0, 32'h0);
    chk("delw_hit", 32'(rh), 1);
    xact(2'd1, 32'h11, 32'h311);
    chk("reuse_hit", 32'(rh), 0); chk("reuse_ok", 32'(rok), 1);
    xact(2'd0, 32'h11, 32'h0);
    chk("reuse_val", rv, 32'h311);
`ifdef HT_STATS_EN
    chk("pre_clr_occ", 32'(occupancy), 4);
    chk("pre_clr_fail", 32'(fail_cnt), 1);
`endif
    xact(2'd3, 32'h0, 32'h0);
    chk("clr_hit", 32'(rh), 0); chk("clr_ok", 32'(rok), 1); chk("clr_lat", lat, B + 1);
`ifdef HT_STATS_EN
    chk("clr_occ", 32'(occupancy), 0);
    chk("clr_fail", 32'(fail_cnt), 1);
`endif
    xact(2'd0, 32'h11, 32'h0); chk("clr_lk_11", 32'(rh), 0);
    xact(2'd0, 32'h5, 32'h0);  chk("clr_lk_5", 32'(rh), 0);
    xact(2'd0, 32'hA, 32'h0);  chk("clr_lk_a", 32'(rh), 0);
    xact(2'd0, 32'hF, 32'h0);  chk("clr_lk_f", 32'(rh), 0); chk("clr_lk_f_val", rv, 0);
    xact(2'd1, 32'h1234, 32'hCC);
    chk("pre_rst_ok", 32'(rok), 1);
    bus.req_op = 2'd3; bus.req_valid = 1'b1; bus.resp_ready = 1'b1;
    @(posedge clk); #1 bus.req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk("midclr_rst_valid", 32'(bus.resp_valid), 0);
    chk("midclr_rst_ready", 32'(bus.req_ready), 1);
    repeat (B + 3) @(posedge clk);
    #1 chk("midclr_no_resp", 32'(bus.resp_valid), 0);
    xact(2'd0, 32'h1234, 32'h0);
    chk("midclr_lk_hit", 32'(rh), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
